regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised multi-port register file with a per-register scoreboard. It sits in the Instruction Decode stage and is the successor to the fixed 32x16, 4-write/8-read register file. New behaviour over the fixed version:
- synchronous reset
- posedge writes with defined write-port priority
- optional write-to-read bypass
- busy bits set at issue and cleared at writeback, so decode can detect RAW hazards

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 32, number of architectural registers; register 0 reads as zero
NUM_WR, 4, write (writeback) ports; port index order is A0, A1, M, LS
NUM_RD, 8, read ports; two per execution unit
NUM_ISS, 2, issue ports that mark destination registers busy
ADDR_W, $clog2(NUM_REGS), register address width (derived)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses, packed, port 0 in LSBs
rd_data  out  NUM_RD*DATA_W  read data, packed
rd_busy  out  NUM_RD  scoreboard busy bit of each read address
wr_en  in  NUM_WR  writeback enables
wr_tag  in  NUM_WR*ADDR_W  writeback destination registers
wr_data  in  NUM_WR*DATA_W  writeback data
iss_en  in  NUM_ISS  issue-mark enables
iss_tag  in  NUM_ISS*ADDR_W  issued destination registers
o_nz_hi  out  2  bit1 = |reg[NUM_REGS-1], bit0 = |reg[NUM_REGS-2]

Behaviour:
- Reset: on posedge clk with rst=1, all registers clear to 0 and all busy bits clear in one cycle. wr_en and iss_en are ignored in that cycle. After reset, rd_data=0, rd_busy=0 and o_nz_hi=0 (combinational from the cleared state).
- Register 0:
  - Never written; never marked busy.
  - A read of address 0 returns 0 with busy=0, whatever wr_en, iss_en or the bypass say.
- Writes:
  - Registered at posedge when wr_en[i]=1 and wr_tag[i]!=0.
  - Same tag on several ports in one cycle: the highest port index wins, so LS beats M beats A1 beats A0.
- Reads:
  - Combinational; zero added latency from rd_addr.
  - Without bypass, a write becomes visible the cycle after its posedge.
- Scoreboard:
  - iss_en[j] with iss_tag[j]!=0 sets busy[tag] at posedge.
  - wr_en[i] with wr_tag[i]!=0 clears busy[tag] at posedge.
  - Set and clear of the same register in the same cycle: set wins, because a new producer supersedes the old one.
  - Duplicate issue tags in one cycle are legal and set the bit once.
  - Clearing a register that is not busy is legal and has no effect.
- rd_busy[k]:
  - Equals the stored busy[rd_addr[k]].
  - With bypass enabled, it is forced to 0 when a same-cycle writeback targets that address.
- o_nz_hi is combinational from the stored registers only; it is never bypassed.
- Out-of-range addresses (when NUM_REGS is not a power of 2): reads return 0, and writes and issues are dropped.
- Reset held across several cycles keeps the state cleared. Reset asserted mid-stream discards all pending busy bits.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - For each read port, if any wr_en[i] has wr_tag[i]==rd_addr[k]!=0 in the same cycle, rd_data[k] is the data of the highest-index matching write port.
  - rd_busy[k] is 0 in that case.
  - This is a purely combinational path from wr_* to rd_*.
- Undefined: rd_data and rd_busy reflect stored state only, and new values appear one cycle after the writeback.

Decomposition:
- Package regfile_pkg holds:
  - default localparams (DATA_W, NUM_REGS, NUM_WR, NUM_RD, NUM_ISS)
  - the wr_port_e enum (WP_A0, WP_A1, WP_M, WP_LS)
  - typedefs reg_addr_t and reg_data_t
- One natural sub-module: regfile_rd_port. It covers one read port: zero-register check, optional bypass priority mux and busy lookup. It is instantiated NUM_RD times via generate.
- Storage, write priority and the scoreboard stay in the top module.

Test Plan:
- Reset: write r5=16'h1234, then assert rst for 1 cycle -> next cycle reading r5 gives 16'h0000, rd_busy=0, o_nz_hi=2'b00.
- Port priority: same cycle, A0 writes r7=16'h0001 and LS writes r7=16'h0002 -> next cycle r7 reads 16'h0002.
- Register 0: write r0=16'hFFFF with iss_tag=0 -> reading r0 gives 16'h0000, busy=0, in the same cycle and after.
- Scoreboard:
  - issue r9 -> rd_busy=1 the next cycle
  - writeback r9=16'hBEEF with a simultaneous issue of r9 -> busy stays 1 and data is 16'hBEEF
  - writeback alone -> busy=0
- Bypass:
  - With REGFILE_BYPASS_EN: write r3=16'hA5A5 while reading r3 -> same-cycle rd_data=16'hA5A5, rd_busy=0.
  - Without REGFILE_BYPASS_EN: same stimulus gives the old value, and 16'hA5A5 next cycle.
- Flags: write r31=16'h0080 and r30=0 -> o_nz_hi=2'b10 the next cycle; write r31=0 -> 2'b00.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, write-port naming and helpers for the
// scoreboarded register file. Optional build macro: REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned NUM_WR   = 4;
    localparam int unsigned NUM_RD   = 8;
    localparam int unsigned NUM_ISS  = 2;

    // Writeback port order; a higher index wins on a same-tag collision.
    typedef enum logic [1:0] {
        WP_A0 = 2'd0,
        WP_A1 = 2'd1,
        WP_M  = 2'd2,
        WP_LS = 2'd3
    } wr_port_e;

    typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]           reg_data_t;

    // True for an address that names a real, writable register (not r0,
    // not beyond the end of a non-power-of-two file).
    function automatic logic addr_ok(input int unsigned a, input int unsigned n);
        return (a != 0) && (a < n);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port of regfile_sb. Applies the zero/out-of-range
// override, the optional same-cycle writeback bypass (REGFILE_BYPASS_EN)
// and passes the stored busy bit.
module regfile_rd_port #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WR = 4
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     addr_valid,
    input  logic [DATA_W-1:0]        stored_data,
    input  logic                     stored_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_tag,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{addr, wr_en, wr_tag, wr_data};
`endif

    // Select stored value, then the highest-index matching writeback, then force r0/invalid to zero
    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy;
`ifdef REGFILE_BYPASS_EN
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_tag[i*ADDR_W +: ADDR_W] == addr)) begin
                rd_data = wr_data[i*DATA_W +: DATA_W];
                rd_busy = 1'b0;
            end
        end
`endif
        if (!addr_valid) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register busy scoreboard.
// r0 reads as zero; writes use highest-port-wins priority; an issue mark
// beats a same-cycle writeback clear. Optional build macro:
// REGFILE_BYPASS_EN (combinational write-to-read forwarding).
module regfile_sb #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned NUM_WR   = regfile_pkg::NUM_WR,
    parameter int unsigned NUM_RD   = regfile_pkg::NUM_RD,
    parameter int unsigned NUM_ISS  = regfile_pkg::NUM_ISS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]  wr_tag,
    input  logic [NUM_WR*DATA_W-1:0]  wr_data,
    input  logic [NUM_ISS-1:0]        iss_en,
    input  logic [NUM_ISS*ADDR_W-1:0] iss_tag,
    output logic [1:0]                o_nz_hi
);
    import regfile_pkg::*;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Storage and scoreboard: later writes override earlier ports, issue marks land after clears
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && addr_ok(32'(wr_tag[i*ADDR_W +: ADDR_W]), NUM_REGS)) begin
                    regs[wr_tag[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
                    busy[wr_tag[i*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            for (int unsigned j = 0; j < NUM_ISS; j++) begin
                if (iss_en[j] && addr_ok(32'(iss_tag[j*ADDR_W +: ADDR_W]), NUM_REGS)) begin
                    busy[iss_tag[j*ADDR_W +: ADDR_W]] <= 1'b1;
                end
            end
        end
    end

    // Flags on the two highest registers come from stored state only
    always_comb begin
        o_nz_hi = {|regs[NUM_REGS-1], |regs[NUM_REGS-2]};
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              a_ok;
        logic [DATA_W-1:0] st_data;
        logic              st_busy;

        assign a       = rd_addr[k*ADDR_W +: ADDR_W];
        assign a_ok    = addr_ok(32'(a), NUM_REGS);
        assign st_data = a_ok ? regs[a] : '0;
        assign st_busy = a_ok ? busy[a] : 1'b0;

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd_port (
            .addr        (a),
            .addr_valid  (a_ok),
            .stored_data (st_data),
            .stored_busy (st_busy),
            .wr_en       (wr_en),
            .wr_tag      (wr_tag),
            .wr_data     (wr_data),
            .rd_data     (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy     (rd_busy[k])
        );
    end

endmodule
